gray_step_sequencer: RTL and testbench

Command-driven controller that sequences a 4-bit reflected Gray code counter. It accepts "advance N steps, one step every I+1 cycles" commands over a valid/ready handshake. It generates the counter's enable pulses, reports completion, and supports abort and clear-on-start. It sits between a control master (CPU-side FSM or test sequencer) and the Gray counter datapath, which is instantiated internally.

---
 rtl/gray_step_sequencer_pkg.sv | 24 ++
 rtl/gray_step_sequencer_counter.sv | 38 +++
 rtl/gray_step_sequencer.sv | 121 ++++++++++++
 tb/tb_gray_step_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_step_sequencer_pkg.sv
// Shared definitions for the Gray step sequencer: state encoding,
// default widths and the binary-to-Gray conversion.
package gray_seq_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int STEP_W_DEF = 8;
   localparam int DIV_W_DEF  = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // Reflected Gray code of a binary value; callers narrow the result.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_step_sequencer_counter.sv
// Gray counter datapath: a binary register advanced by one, presented as
// its reflected Gray code. Clear takes priority over advance.
module gray_counter_core
   import gray_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             adv,
   output logic [WIDTH-1:0] gray
);

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] bin_d;

   always_comb begin
      bin_d = bin_q;
      if (clr) begin
         bin_d = '0;
      end else if (adv) begin
         bin_d = bin_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q <= '0;
      end else begin
         bin_q <= bin_d;
      end
   end

   // Gray output depends only on the register, so it changes only at edges.
   assign gray = WIDTH'(bin2gray(32'(bin_q)));

endmodule

// File: rtl/gray_step_sequencer.sv
// Command-driven sequencer: accepts "advance N steps every I+1 cycles",
// paces enable pulses to the Gray counter, and reports completion or abort.
module gray_step_sequencer
   import gray_seq_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STEP_W = STEP_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0]  cmd_interval,
   input  logic              cmd_clear,
   input  logic              abort,
   output logic [WIDTH-1:0]  gray_count,
   output logic [STEP_W-1:0] steps_left,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [DIV_W-1:0]  timer_q, timer_d;
   logic [DIV_W-1:0]  ival_q, ival_d;
   logic              aborted_q, aborted_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              adv;
   logic              clr;

   always_comb begin
      state_d   = state_q;
      steps_d   = steps_q;
      timer_d   = timer_q;
      ival_d    = ival_q;
      aborted_d = aborted_q;
      adv       = 1'b0;
      clr       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               steps_d   = cmd_steps;
               timer_d   = cmd_interval;
               ival_d    = cmd_interval;
               clr       = cmd_clear;
               aborted_d = 1'b0;
               state_d   = (cmd_steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Abort beats a due advance: the step count freezes as it stands.
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (timer_q == '0) begin
               adv     = 1'b1;
               steps_d = steps_q - STEP_W'(1);
               timer_d = ival_q;
               if (steps_q == STEP_W'(1)) begin
                  state_d = DONE;
               end
            end else begin
               timer_d = timer_q - DIV_W'(1);
            end
         end
         DONE: begin
            aborted_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Status flags are registered from the next state so they align with it.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         steps_q   <= '0;
         timer_q   <= '0;
         ival_q    <= '0;
         aborted_q <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         steps_q   <= steps_d;
         timer_q   <= timer_d;
         ival_q    <= ival_d;
         aborted_q <= aborted_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   gray_counter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .adv  (adv),
      .gray (gray_count)
   );

   assign cmd_ready  = ready_q;
   assign steps_left = steps_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Scoreboard bench for gray_step_sequencer: commands push expected Gray
// changes and completions; a monitor compares them each cycle.
module tb_gray_step_sequencer;

   localparam int WIDTH  = 4;
   localparam int STEP_W = 8;
   localparam int DIV_W  = 8;

   localparam logic [3:0] SEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic [DIV_W-1:0]  cmd_interval = '0;
   logic              cmd_clear = 1'b0;
   logic              abort = 1'b0;
   logic [WIDTH-1:0]  gray_count;
   logic [STEP_W-1:0] steps_left;
   logic              busy;
   logic              done;
   logic              aborted;

   gray_step_sequencer #(
      .WIDTH(WIDTH), .STEP_W(STEP_W), .DIV_W(DIV_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_steps   (cmd_steps),
      .cmd_interval(cmd_interval),
      .cmd_clear   (cmd_clear),
      .abort       (abort),
      .gray_count  (gray_count),
      .steps_left  (steps_left),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] val;
      bit         step;
   } gev_t;

   typedef struct {
      int         cyc;
      bit         ab;
      int         left;
      logic [3:0] val;
   } dev_t;

   gev_t aq[$];
   dev_t dq[$];

   int         total = 0;
   int         bad = 0;
   int         pos = 0;
   bit         mon_en = 1'b0;
   bit         win_valid = 1'b0;
   int         win_e0 = 0, win_end = 0, win_n = 0, win_per = 1, win_adv = 0;
   int         last_end = 0;
   int         reset_edge = 0;
   logic [3:0] last_gray = 4'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   gev_t mg;
   dev_t md;
   int   mk;
   bit   mbusy;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (aq.size() > 0 && aq[0].cyc == cyc) begin
            mg = aq.pop_front();
            chk("gray_change", 32'(gray_count), 32'(mg.val));
            if (mg.step) chk("one_bit", $countones(gray_count ^ last_gray), 1);
         end else begin
            chk("gray_hold", 32'(gray_count), 32'(last_gray));
         end
         last_gray = gray_count;

         if (dq.size() > 0 && dq[0].cyc == cyc) begin
            md = dq.pop_front();
            chk("done_pulse", 32'(done), 32'(1));
            chk("done_aborted", 32'(aborted), 32'(md.ab));
            chk("done_steps_left", 32'(steps_left), md.left);
            chk("done_gray", 32'(gray_count), 32'(md.val));
            chk("done_ready", 32'(cmd_ready), 32'(0));
         end else begin
            chk("no_done", 32'(done), 32'(0));
            chk("no_aborted", 32'(aborted), 32'(0));
         end

         mbusy = win_valid && cyc >= win_e0 && cyc <= win_end;
         chk("busy", 32'(busy), 32'(mbusy));
         if (mbusy) begin
            chk("ready_busy", 32'(cmd_ready), 32'(0));
            mk = (cyc - win_e0) / win_per;
            if (mk > win_adv) mk = win_adv;
            chk("steps_left", 32'(steps_left), win_n - mk);
         end
      end
   end

   // Issue one command; the model predicts every Gray change and the done pulse.
   task automatic issue(input int n, input int iv, input bit clr, input int aoff,
                        input int exp_e0, input bit hold, input bit nowait);
      int t, e0, per, nadv, endc;
      bit ab;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (cmd_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ready_timeout cyc=%0d got=%0b want=1", cyc, cmd_ready);
         return;
      end
      cmd_valid    = 1'b1;
      cmd_steps    = STEP_W'(n);
      cmd_interval = DIV_W'(iv);
      cmd_clear    = clr;
      if (aoff == 0) abort = 1'($urandom_range(0, 1));
      e0 = cyc + 1;
      if (exp_e0 >= 0) chk("accept_edge", e0, exp_e0);
      per = iv + 1;
      if (aoff > 0) begin
         nadv = (aoff - 1) / per;
         endc = e0 + aoff;
         ab   = 1'b1;
      end else begin
         nadv = n;
         endc = e0 + n * per;
         ab   = 1'b0;
      end
      if (clr && pos != 0) aq.push_back(gev_t'{e0, 4'h0, 1'b0});
      if (clr) pos = 0;
      for (int k = 1; k <= nadv; k++) aq.push_back(gev_t'{e0 + k * per, SEQ[(pos + k) % 16], 1'b1});
      pos = (pos + nadv) % 16;
      dq.push_back(dev_t'{endc, ab, n - nadv, SEQ[pos]});
      win_e0 = e0; win_end = endc; win_n = n; win_per = per; win_adv = nadv;
      win_valid = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      if (!hold && !nowait) begin
         cmd_valid    = 1'b0;
         cmd_steps    = STEP_W'($urandom);
         cmd_interval = DIV_W'($urandom);
         cmd_clear    = 1'($urandom_range(0, 1));
      end
      if (aoff > 0) begin
         while (cyc < e0 + aoff - 1) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      if (!nowait) begin
         while (cyc < endc) @(negedge clk);
      end
      last_end = endc;
   endtask

   // Reset mid-stream: pending work is dropped and the counter returns to 0.
   task automatic do_reset();
      aq.delete();
      dq.delete();
      win_valid = 1'b0;
      if (pos != 0) aq.push_back(gev_t'{cyc + 1, 4'h0, 1'b0});
      pos = 0;
      reset = 1'b1;
      @(negedge clk);
      reset_edge = cyc;
      chk("rst_ready", 32'(cmd_ready), 32'(0));
      chk("rst_steps_left", 32'(steps_left), 32'(0));
      chk("rst_gray", 32'(gray_count), 32'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_ready), 32'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, iv, aoff;
      bit clr, hold, prev_hold;
      repeat (3) @(negedge clk);
      chk("init_gray", 32'(gray_count), 32'(0));
      chk("init_steps_left", 32'(steps_left), 32'(0));
      chk("init_busy", 32'(busy), 32'(0));
      chk("init_done", 32'(done), 32'(0));
      chk("init_aborted", 32'(aborted), 32'(0));
      chk("init_ready", 32'(cmd_ready), 32'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("init_ready_up", 32'(cmd_ready), 32'(1));
      last_gray = 4'h0;
      mon_en = 1'b1;

      issue(3, 0, 1'b1, 0, -1, 1'b0, 1'b0);
      @(negedge clk);
      chk("ready_after_done", 32'(cmd_ready), 32'(1));
      issue(2, 2, 1'b1, 0, -1, 1'b0, 1'b0);
      issue(16, 0, 1'b1, 0, -1, 1'b0, 1'b0);
      issue(10, 1, 1'b1, 7, -1, 1'b0, 1'b0);
      issue(0, 3, 1'b0, 0, -1, 1'b0, 1'b0);
      issue(2, 0, 1'b0, 0, -1, 1'b1, 1'b0);
      issue(2, 0, 1'b0, 0, last_end + 2, 1'b0, 1'b0);

      issue(20, 1, 1'b0, 0, -1, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      do_reset();
      issue(3, 0, 1'b0, 0, reset_edge + 2, 1'b0, 1'b0);

      prev_hold = 1'b0;
      for (int r = 0; r < 30; r++) begin
         n  = $urandom_range(0, 20);
         iv = $urandom_range(0, 3);
         if (r % 10 == 9) begin
            n  = $urandom_range(200, 255);
            iv = 0;
         end
         clr  = ($urandom_range(0, 3) == 0);
         aoff = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * (iv + 1)) : 0;
         hold = ($urandom_range(0, 3) == 0);
         issue(n, iv, clr, aoff, prev_hold ? last_end + 2 : -1, hold, 1'b0);
         prev_hold = hold;
      end

      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("gray_queue_empty", aq.size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
